// File: rtl/ex_muldiv.sv
// EX-stage HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU iterative (32 CALC + 1 FIX), MTHI/MTLO direct.
// Latency: iterative ops show hi/lo/done 33 edges after accept; MTHI/MTLO 1 edge; fast multiply 1 edge.
// Backpressure: stall_req = busy & (start | mf_req); requests while busy wait for DONE. Option: MULDIV_FAST_MUL_EN.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall_req
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] opa;      // multiplicand / dividend magnitude
  logic [31:0] opb;      // multiplier / divisor magnitude
  logic [63:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic        is_div;
  logic        neg_q;    // negate product or quotient in FIX
  logic        neg_r;    // negate remainder in FIX

  // Operand sign handling: signed ops work on magnitudes, signs are fixed up afterwards.
  logic        signed_op;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign rs_neg    = signed_op & rs_val[31];
  assign rt_neg    = signed_op & rt_val[31];
  assign rs_mag    = rs_neg ? (~rs_val + 32'd1) : rs_val;
  assign rt_mag    = rt_neg ? (~rt_val + 32'd1) : rt_val;

  // One shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

  // One restoring step: shift in the next dividend bit, subtract divisor if it fits.
  // 34-bit difference so a zero divisor never reports a false borrow (quotient becomes all ones,
  // remainder collects the dividend).
  logic [33:0] div_diff;
  logic [63:0] div_next;
  assign div_diff = {1'b0, acc[63:31]} - {2'b00, opb};
  assign div_next = div_diff[33] ? {acc[62:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

  // Sign correction applied in FIX.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
  assign quo_fix  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product from sign- or zero-extended operands; low 64 bits are exact for both.
  logic [63:0] fast_prod;
  assign fast_prod = {{32{rs_neg}}, rs_val} * {{32{rt_neg}}, rt_val};
`endif

  // Hazard request: only while an iterative op is running.
  assign stall_req = busy & (start | mf_req);

  // Main FSM: accepts requests in IDLE/DONE, iterates in CALC, fixes signs in FIX, writes HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      acc    <= 64'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE lasts one cycle; a request held during the stall is taken here.
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                hi    <= fast_prod[63:32];
                lo    <= fast_prod[31:0];
                state <= DONE;
                done  <= 1'b1;
`else
                opa    <= rs_mag;
                opb    <= rt_mag;
                acc    <= {32'd0, rt_mag};
                is_div <= 1'b0;
                neg_q  <= rs_neg ^ rt_neg;
                neg_r  <= 1'b0;
                cnt    <= 6'd0;
                state  <= CALC;
                busy   <= 1'b1;
`endif
              end
              OP_DIV, OP_DIVU: begin
                opa    <= rs_mag;
                opb    <= rt_mag;
                acc    <= {32'd0, rs_mag};
                is_div <= 1'b1;
                // Divide by zero keeps the all-ones quotient unsigned-looking.
                neg_q  <= (rs_neg ^ rt_neg) & (rt_val != 32'd0);
                neg_r  <= rs_neg;
                cnt    <= 6'd0;
                state  <= CALC;
                busy   <= 1'b1;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt == 6'd31) begin
            cnt   <= 6'd0;
            state <= FIX;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: scoreboard of expected {hi,lo} checked on each done pulse.
// Covers reset, signed/unsigned mul/div, divide corner cases, MTHI/MTLO, stall, mid-op reset.
// Latency of multiply follows MULDIV_FAST_MUL_EN.
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        mf_req = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall_req;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mf_req    (mf_req),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results from plain SV arithmetic: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] a32;
    logic signed [31:0] b32;
    logic signed [31:0] q;
    logic signed [31:0] r;
    logic [63:0] res;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    a32 = a;
    b32 = b;
    res = 64'd0;
    case (o)
      3'd0: res = sa * sb;
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'd0, 32'h80000000};
        else begin
          q   = a32 / b32;
          r   = a32 % b32;
          res = {r, q};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Issue one mul/div op, check busy each cycle, latency, result and single-cycle done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int lat;
    logic got;
    logic [63:0] e;
    lat = (o <= 3'd1) ? MUL_LAT : DIV_LAT;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= lat + 2 && !got; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      chk({tag, "_busy"}, busy, (k < lat));
      if (done) begin
        got = 1'b1;
        chk({tag, "_lat"}, k, lat);
        e = sb_q.pop_front();
        chk({tag, "_hi"}, hi, e[63:32]);
        chk({tag, "_lo"}, lo, e[31:0]);
      end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 0, 1);
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [63:0] e;
    logic hit;
    logic [2:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Directed vectors
    run_op("mult_m2x3", 3'd0, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA});
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("div_5_0", 3'd2, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
    run_op("div_min_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
    run_op("multu_max_2", 3'd1, 32'hFFFFFFFF, 32'd2, {32'd1, 32'hFFFFFFFE});
    run_op("multu_max_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});

    // MTHI / MTLO: one edge, no busy, no done
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs_val = 32'hA5A5_0001;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5_0001);
    chk("mthi_busy", busy, 1'b0);
    chk("mthi_done", done, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs_val = 32'h5A5A_0002;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h5A5A_0002);
    chk("mtlo_hi_kept", hi, 32'hA5A5_0001);
    chk("mtlo_done", done, 1'b0);

    // Stall: mf_req from cycle 5, start pulse during CALC must be ignored
    sb_q.push_back(model(3'd3, 32'd1000, 32'd3));
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 1; k <= DIV_LAT + 2 && !hit; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 5) mf_req = 1'b1;
      if (k == 10) begin start = 1'b1; op = 3'd5; rs_val = 32'hDEAD; end
      if (k == 12) start = 1'b0;
      #1;
      if (done) begin
        hit = 1'b1;
        chk("stall_done_lat", k, DIV_LAT);
        chk("stall_done_stall", stall_req, 1'b0);
        e = sb_q.pop_front();
        chk("stall_hi", hi, e[63:32]);
        chk("stall_lo", lo, e[31:0]);
      end else begin
        chk("stall_req", stall_req, (k >= 5));
      end
    end
    if (!hit) begin
      chk("stall_timeout", 0, 1);
      void'(sb_q.pop_front());
    end
    mf_req = 1'b0;
    @(posedge clk); #1;
    chk("stall_lo_kept", lo, 32'd333);
    chk("stall_pulse", done, 1'b0);

    // Mid-operation reset aborts MULTU, then MTLO works on the first edge
    @(negedge clk);
    start = 1'b1; op = 3'd1; rs_val = 32'h0001_0001; rt_val = 32'h0000_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    mf_req = 1'b1;
    #1;
    chk("abort_busy_pre", busy, (10 < MUL_LAT));
    chk("abort_stall_pre", stall_req, (10 < MUL_LAT));
    rst = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_stall", stall_req, 1'b0);
    mf_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    start = 1'b1; op = 3'd5; rs_val = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_rst_lo", lo, 32'h1234);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_busy", busy, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_no_done", done, 1'b0);
    chk("post_rst_lo_kept", lo, 32'h1234);

    // Random mul/div against the reference model
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 3) ra = 32'h8000_0000;
      run_op("rand", ro, ra, rb, model(ro, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
